fifo_rd_stream: RTL

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_rd_stream.sv | 117 +++++++++++
 1 files changed

// File: rtl/fifo_rd_stream.sv
// Pulls words from a registered-output FIFO read port and presents them as a valid/ready stream
// through a 2-entry skid buffer, counting completed transfers.
module fifo_rd_stream #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    output logic                  o_fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] i_fifo_rd_data,
    input  logic                  i_fifo_rd_empty,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_ready,
    output logic [CNT_WIDTH-1:0]  o_xfer_cnt
);

    localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    state_e                r_state;
    state_e                w_state_nxt;
    logic                  r_pending;
    logic                  r_run;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;
    logic [DATA_WIDTH-1:0] w_head_nxt;
    logic [DATA_WIDTH-1:0] w_tail_nxt;
    logic [CNT_WIDTH-1:0]  r_xfer_cnt;

    logic                  w_pop;
    logic                  w_push;
    logic [1:0]            w_entries;
    logic [1:0]            w_occ;

    assign o_valid    = (r_state != StEmpty);
    assign o_data     = r_head;
    assign o_xfer_cnt = r_xfer_cnt;

    // Occupancy counts in-flight reads and credits a word leaving this cycle, so a full
    // buffer that is draining can still request and sustain one word per cycle.
    always_comb begin
        w_pop     = o_valid && i_ready;
        w_push    = r_pending;
        w_entries = 2'd0;
        unique case (r_state)
            StEmpty: w_entries = 2'd0;
            StOne:   w_entries = 2'd1;
            StTwo:   w_entries = 2'd2;
            default: w_entries = 2'd0;
        endcase
        w_occ        = w_entries + {1'b0, r_pending} - {1'b0, w_pop};
        // r_run holds off requests until the first edge after reset release.
        o_fifo_rd_en = r_run && !i_fifo_rd_empty && (w_occ < 2'd2);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        unique case (r_state)
            StEmpty: begin
                if (w_push) begin
                    w_head_nxt  = i_fifo_rd_data;
                    w_state_nxt = StOne;
                end
            end
            StOne: begin
                if (w_push && w_pop) begin
                    w_head_nxt = i_fifo_rd_data;
                end else if (w_push) begin
                    w_tail_nxt  = i_fifo_rd_data;
                    w_state_nxt = StTwo;
                end else if (w_pop) begin
                    w_state_nxt = StEmpty;
                end
            end
            StTwo: begin
                if (w_pop) begin
                    w_head_nxt  = r_tail;
                    w_state_nxt = StOne;
                end
            end
            default: w_state_nxt = StEmpty;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StEmpty;
            r_pending  <= 1'b0;
            r_run      <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
            r_xfer_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= o_fifo_rd_en;
            r_run     <= 1'b1;
            r_head    <= w_head_nxt;
            r_tail    <= w_tail_nxt;
            if (w_pop) begin
                r_xfer_cnt <= r_xfer_cnt + CntOne;
            end
        end
    end

    // A landing read while both entries are occupied would overwrite or drop a word.
    ast_no_push_in_two: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(r_pending && (r_state == StTwo)));

endmodule
